alu_bh_16: RTL and testbench
============================

Name: alu_bh_16

Overview:
- Registered 16-operation ALU with 4-bit operands x, y, a 4-bit opcode and an 8-bit result z.
- Covers arithmetic, comparison, bitwise, shift and inverted-logic operations.
- Used as a small compute leaf in datapath blocks.
- Single clock domain; result appears one cycle after the operands are presented.

Parameters:
- none. All widths are fixed: operands 4 bits, opcode 4 bits, result 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x  input  4  operand A, unsigned
- y  input  4  operand B, unsigned
- opcode  input  4  operation select
- in_valid  input  1  operands and opcode are valid this cycle
- z  output  8  registered result, unsigned
- out_valid  output  1  z holds a new result this cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: rst_n low asynchronously forces z=8'h00 and out_valid=0. Release is synchronous to clk.
- Latency: one cycle.
  - If in_valid=1 at rising edge N, z is loaded with f(x,y,opcode) and out_valid=1 after edge N.
  - If in_valid=0, z holds its previous value and out_valid=0.
- Throughput: one operation per cycle. There is no backpressure.
- Width rule: x and y are zero-extended to 8 bits before the operation. The result is truncated to 8 bits.
- Opcode map (result z):
  - 0 add: x+y (max 30)
  - 1 sub: (x-y) mod 256. Two's-complement wrap when y>x.
  - 2 mul: x*y (max 225)
  - 3 div: x/y integer quotient. If y=0, z=8'hFF.
  - 4 gt: 1 if x>y, else 0
  - 5 lt: 1 if x<y, else 0
  - 6 eq: 1 if x==y, else 0
  - 7 and: x&y
  - 8 or: x|y
  - 9 xor: x^y
  - 10 shl: x<<y in 8 bits. Bits shifted past bit 7 are lost, so y>=8 gives 0.
  - 11 shr: x>>y. y>=4 gives 0.
  - 12 not: {4'h0, ~x}
  - 13 nand: {4'h0, ~(x&y)}
  - 14 nor: {4'h0, ~(x|y)}
  - 15 xnor: {4'h0, ~(x^y)}
- Inverted ops produce a 4-bit result; upper nibble of z is always 0 for opcodes 7-15 except shl.
- Comparisons drive bits 7:1 to 0.
- No X propagation: all 16 opcodes are decoded; there are no illegal codes.
- Reset mid-operation: a result in flight is discarded. out_valid=0 until the next accepted in_valid.

Optional Feature:
- Macro: ALU_FLAGS_EN
- When defined, two extra registered outputs are added. Both are updated under the same in_valid rule as z and reset to 0.
  - zero_flag (1 bit): 1 when the computed 8-bit result is 0.
  - dz_flag (1 bit): 1 when opcode=3 and y=0.
- When undefined, these ports and their logic are absent. Core behaviour is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> z=0 and out_valid=0 immediately, without waiting for a clock edge.
- Full sweep: x=10, y=3, opcode 0..15 with in_valid=1 each cycle -> z next cycle = 13, 7, 30, 3, 1, 0, 0, 2, 11, 9, 80, 1, 5, 13, 4, 6.
- Wrap and extremes:
  - x=3, y=10, op1 -> z=249
  - x=15, y=15, op2 -> z=225
  - x=15, y=15, op0 -> z=30
  - x=15, y=15, op6 -> z=1
- Divide by zero: x=9, y=0, op3 -> z=255. With ALU_FLAGS_EN: dz_flag=1, zero_flag=0.
- Shifts:
  - x=15, y=4, op10 -> z=240
  - x=15, y=8, op10 -> z=0
  - x=8, y=3, op11 -> z=1
  - x=8, y=4, op11 -> z=0, and zero_flag=1 if ALU_FLAGS_EN is defined
- Hold: drop in_valid=0 after a result of 13 -> z stays 13 and out_valid=0 while x, y and opcode change.

Source files
------------

// File: rtl/alu_bh_16.sv
// Registered 16-operation ALU: 4-bit operands, 8-bit result, one-cycle latency.
// Optional zero/divide-by-zero flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_bh_16 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [3:0] opcode,
  input  logic       in_valid,
  output logic [7:0] z,
  output logic       out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic       zero_flag,
  output logic       dz_flag
`endif
);

  logic [7:0] x_ext;
  logic [7:0] y_ext;
  logic [7:0] mul_full;
  logic [7:0] result_next;

  assign x_ext    = {4'h0, x};
  assign y_ext    = {4'h0, y};
  assign mul_full = x_ext * y_ext;

  always_comb begin
    result_next = 8'h00;
    unique case (opcode)
      4'd0:  result_next = x_ext + y_ext;
      4'd1:  result_next = x_ext - y_ext;
      4'd2:  result_next = mul_full;
      4'd3:  result_next = (y == 4'h0) ? 8'hFF : (x_ext / y_ext);
      4'd4:  result_next = {7'd0, (x > y)};
      4'd5:  result_next = {7'd0, (x < y)};
      4'd6:  result_next = {7'd0, (x == y)};
      4'd7:  result_next = {4'h0, x & y};
      4'd8:  result_next = {4'h0, x | y};
      4'd9:  result_next = {4'h0, x ^ y};
      // Shifting the zero-extended operand drops bits past bit 7 naturally.
      4'd10: result_next = x_ext << y;
      4'd11: result_next = x_ext >> y;
      4'd12: result_next = {4'h0, ~x};
      4'd13: result_next = {4'h0, ~(x & y)};
      4'd14: result_next = {4'h0, ~(x | y)};
      4'd15: result_next = {4'h0, ~(x ^ y)};
      default: result_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z <= result_next;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      dz_flag   <= 1'b0;
    end else if (in_valid) begin
      zero_flag <= (result_next == 8'h00);
      dz_flag   <= (opcode == 4'd3) && (y == 4'h0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_bh_16.sv
// Scoreboard bench for alu_bh_16: expected results are queued at drive time
// and popped when out_valid is due; held values are checked on idle cycles.
module tb_alu_bh_16;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] opcode;
  logic       in_valid;
  logic [7:0] z;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       zero_flag;
  logic       dz_flag;
`endif

  int errors;
  int checks;

  // Each entry: {dz, zero, z}
  logic [9:0] sb_q[$];
  logic       pend;
  logic [9:0] hold_e;

  alu_bh_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .opcode    (opcode),
    .in_valid  (in_valid),
    .z         (z),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .zero_flag (zero_flag),
    .dz_flag   (dz_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input int a, input int b, input int op);
    int r;
    r = 0;
    case (op)
      0:  r = a + b;
      1:  r = (a - b + 256) % 256;
      2:  r = a * b;
      3:  r = (b == 0) ? 255 : a / b;
      4:  r = (a > b) ? 1 : 0;
      5:  r = (a < b) ? 1 : 0;
      6:  r = (a == b) ? 1 : 0;
      7:  r = a & b;
      8:  r = a | b;
      9:  r = a ^ b;
      10: r = (a << b) & 255;
      11: r = a >> b;
      12: r = 15 - a;
      13: r = 15 - (a & b);
      14: r = 15 - (a | b);
      15: r = 15 - (a ^ b);
      default: r = 0;
    endcase
    r = r & 255;
    model = {(op == 3 && b == 0), (r == 0), r[7:0]};
  endfunction

  task automatic compare_outputs();
    logic [9:0] e;
    check_val("out_valid", {31'd0, out_valid}, {31'd0, pend});
    if (pend) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
        e = hold_e;
      end else begin
        e = sb_q.pop_front();
      end
      hold_e = e;
      check_val("z", {24'd0, z}, {24'd0, e[7:0]});
    end else begin
      e = hold_e;
      check_val("z_hold", {24'd0, z}, {24'd0, e[7:0]});
    end
`ifdef ALU_FLAGS_EN
    check_val("zero_flag", {31'd0, zero_flag}, {31'd0, e[8]});
    check_val("dz_flag", {31'd0, dz_flag}, {31'd0, e[9]});
`endif
    $display("txn t=%0t out_valid=%0b z=%0d exp_z=%0d", $time, out_valid, z, e[7:0]);
  endtask

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    @(negedge clk);
    compare_outputs();
    x        = a;
    y        = b;
    opcode   = op;
    in_valid = v;
    pend     = v;
    if (v) sb_q.push_back(model(int'(a), int'(b), int'(op)));
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    pend     = 1'b0;
    hold_e   = 10'd0;
    x        = 4'd0;
    y        = 4'd0;
    opcode   = 4'd0;
    in_valid = 1'b0;
    rst_n    = 1'b0;

    #12;
    check_val("reset_z", {24'd0, z}, 32'd0);
    check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full opcode sweep with x=10, y=3
    for (int op = 0; op < 16; op++) step(1'b1, 4'd10, 4'd3, op[3:0]);

    // Wrap, extremes, divide by zero, shifts
    step(1'b1, 4'd3,  4'd10, 4'd1);
    step(1'b1, 4'd15, 4'd15, 4'd2);
    step(1'b1, 4'd15, 4'd15, 4'd0);
    step(1'b1, 4'd15, 4'd15, 4'd6);
    step(1'b1, 4'd9,  4'd0,  4'd3);
    step(1'b1, 4'd15, 4'd4,  4'd10);
    step(1'b1, 4'd15, 4'd8,  4'd10);
    step(1'b1, 4'd8,  4'd3,  4'd11);
    step(1'b1, 4'd8,  4'd4,  4'd11);

    // Hold: result 13 then idle with changing inputs
    step(1'b1, 4'd10, 4'd3, 4'd0);
    step(1'b0, 4'd1,  4'd2, 4'd2);
    step(1'b0, 4'd7,  4'd5, 4'd9);
    step(1'b0, 4'd15, 4'd0, 4'd3);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    end

    // Asynchronous reset with a result in flight
    step(1'b1, 4'd12, 4'd5, 4'd2);
    @(posedge clk);
    step(1'b1, 4'd6, 4'd6, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_z", {24'd0, z}, 32'd0);
    check_val("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    sb_q.delete();
    pend   = 1'b0;
    hold_e = 10'd0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    step(1'b0, 4'd0, 4'd0, 4'd0);
    step(1'b1, 4'd7, 4'd2, 4'd3);
    step(1'b0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0, 4'd0);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
